regfile_bypass_stage: RTL and testbench

Parametrised register-read stage for the pipelined RV32I core: multi-port write register file, registered operand selection with same-cycle write bypass, and a configurable load-use hazard window that drops the dependent instruction and requests a refetch. Sits between decode and execute. Successor to the fixed two-write-port, fixed-window read stage, with operand-mode selection, pipeline flush and a parametrised window.

---
 rtl/regfile_bypass_stage.sv | 198 +++++++++++++++++++
 tb/tb_regfile_bypass_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_stage.sv
// Register-read stage: multi-port register file, same-cycle write bypass,
// operand selection and a load-use hazard window that drops dependents.
module regfile_bypass_stage #(
    parameter int XLEN           = 32,
    parameter int REG_CNT        = 32,
    parameter int REG_ID_W       = 6,
    parameter int WR_PORTS       = 2,
    parameter int LOAD_WIN       = 4,
    parameter int REGS_INIT_ZERO = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         id_valid,
    input  logic [REG_ID_W-1:0]          id_rs1,
    input  logic [REG_ID_W-1:0]          id_rs2,
    input  logic [REG_ID_W-1:0]          id_rd,
    input  logic                         id_use_rs2,
    input  logic                         id_is_load,
    input  logic [1:0]                   id_op1_mode,
    input  logic [1:0]                   id_op2_mode,
    input  logic [XLEN-1:0]              id_imm,
    input  logic [XLEN-1:0]              id_pc,
    input  logic                         flush,
    input  logic [WR_PORTS-1:0]          wr_valid,
    input  logic [WR_PORTS*REG_ID_W-1:0] wr_id,
    input  logic [WR_PORTS*XLEN-1:0]     wr_data,
    output logic                         ex_valid,
    output logic [XLEN-1:0]              ex_op1,
    output logic [XLEN-1:0]              ex_op2,
    output logic [REG_ID_W-1:0]          ex_rd,
    output logic                         load_hazard_o,
    output logic [XLEN-1:0]              refetch_pc_o
);

    // Register 0 is hard-wired, so storage starts at 1.
    logic [XLEN-1:0]     regs_r   [1:REG_CNT-1];
    logic                wr_en_s  [1:REG_CNT-1];
    logic [XLEN-1:0]     wr_val_s [1:REG_CNT-1];
    logic [XLEN-1:0]     fwd_s    [1:REG_CNT-1];

    logic [LOAD_WIN-1:0] win_valid_r;
    logic [REG_ID_W-1:0] win_rd_r [LOAD_WIN];

    logic [XLEN-1:0]     rs1_val_s;
    logic [XLEN-1:0]     rs2_val_s;
    logic [XLEN-1:0]     op1_s;
    logic [XLEN-1:0]     op2_s;
    logic                use_rs1_s;
    logic                use_rs2_s;
    logic                hazard_s;
    logic                push_s;

    // Operand 1 is a register for modes 0 and 3.
    function automatic logic op1_reads_reg(input logic [1:0] mode);
        return (mode == 2'd0) || (mode == 2'd3);
    endfunction

    // Per-register write resolution; ports scanned high to low so port 0 wins.
    always_comb begin
        for (int r = 1; r < REG_CNT; r++) begin
            wr_en_s[r]  = 1'b0;
            wr_val_s[r] = '0;
            for (int p = WR_PORTS - 1; p >= 0; p--) begin
                if (wr_valid[p] && (wr_id[p*REG_ID_W +: REG_ID_W] == REG_ID_W'(r))) begin
                    wr_en_s[r]  = 1'b1;
                    wr_val_s[r] = wr_data[p*XLEN +: XLEN];
                end else begin
                    wr_en_s[r]  = wr_en_s[r];
                    wr_val_s[r] = wr_val_s[r];
                end
            end
            fwd_s[r] = wr_en_s[r] ? wr_val_s[r] : regs_r[r];
        end
    end

    // Source reads see same-cycle writes; id 0 and out-of-range ids read 0.
    always_comb begin
        rs1_val_s = '0;
        rs2_val_s = '0;
        for (int r = 1; r < REG_CNT; r++) begin
            if (id_rs1 == REG_ID_W'(r)) begin
                rs1_val_s = fwd_s[r];
            end else begin
                rs1_val_s = rs1_val_s;
            end
            if (id_rs2 == REG_ID_W'(r)) begin
                rs2_val_s = fwd_s[r];
            end else begin
                rs2_val_s = rs2_val_s;
            end
        end
    end

    // Operand multiplexers.
    always_comb begin
        op1_s = '0;
        op2_s = '0;
        case (id_op1_mode)
            2'd0:    op1_s = rs1_val_s;
            2'd1:    op1_s = id_pc;
            2'd2:    op1_s = '0;
            2'd3:    op1_s = rs1_val_s;
            default: op1_s = rs1_val_s;
        endcase
        case (id_op2_mode)
            2'd0:    op2_s = rs2_val_s;
            2'd1:    op2_s = id_imm;
            2'd2:    op2_s = XLEN'(32'd4);
            2'd3:    op2_s = {{(XLEN-5){1'b0}}, id_rs2[4:0]};
            default: op2_s = rs2_val_s;
        endcase
    end

    // Load-use detection against every live window entry.
    always_comb begin
        use_rs1_s = op1_reads_reg(id_op1_mode);
        use_rs2_s = id_use_rs2 && (id_op2_mode == 2'd0);
        hazard_s  = 1'b0;
        for (int i = 0; i < LOAD_WIN; i++) begin
            if (win_valid_r[i] && (win_rd_r[i] != '0) &&
                ((use_rs1_s && (win_rd_r[i] == id_rs1)) ||
                 (use_rs2_s && (win_rd_r[i] == id_rs2)))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        hazard_s = hazard_s && id_valid && !flush;
        push_s   = id_valid && id_is_load && !hazard_s && !flush;
    end

    generate
        if (REGS_INIT_ZERO != 0) begin : g_arr_clr
            // Register array, cleared on reset.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int r = 1; r < REG_CNT; r++) begin
                        regs_r[r] <= '0;
                    end
                end else begin
                    for (int r = 1; r < REG_CNT; r++) begin
                        if (wr_en_s[r]) begin
                            regs_r[r] <= wr_val_s[r];
                        end
                    end
                end
            end
        end else begin : g_arr_keep
            // Register array, contents undefined after reset.
            always_ff @(posedge clk) begin
                for (int r = 1; r < REG_CNT; r++) begin
                    if (wr_en_s[r]) begin
                        regs_r[r] <= wr_val_s[r];
                    end
                end
            end
        end
    endgenerate

    // Load window shift register; entry i holds the load from i+1 edges ago.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_valid_r <= '0;
            for (int i = 0; i < LOAD_WIN; i++) begin
                win_rd_r[i] <= '0;
            end
        end else begin
            win_valid_r[0] <= push_s;
            win_rd_r[0]    <= id_rd;
            for (int i = 1; i < LOAD_WIN; i++) begin
                win_valid_r[i] <= flush ? 1'b0 : win_valid_r[i-1];
                win_rd_r[i]    <= win_rd_r[i-1];
            end
        end
    end

    // Execute-side output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid      <= 1'b0;
            ex_op1        <= '0;
            ex_op2        <= '0;
            ex_rd         <= '0;
            load_hazard_o <= 1'b0;
            refetch_pc_o  <= '0;
        end else begin
            ex_valid      <= id_valid && !flush && !hazard_s;
            ex_op1        <= op1_s;
            ex_op2        <= op2_s;
            ex_rd         <= id_rd;
            load_hazard_o <= hazard_s;
            if (hazard_s) begin
                refetch_pc_o <= id_pc;
            end
        end
    end

endmodule

// File: tb/tb_regfile_bypass_stage.sv
// Directed-vector bench for regfile_bypass_stage; a scoreboard queue holds the
// expected response of every issued cycle and a monitor checks it.
module tb_regfile_bypass_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid;
    logic [5:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs2, id_is_load;
    logic [1:0]  id_op1_mode, id_op2_mode;
    logic [31:0] id_imm, id_pc;
    logic        flush;
    logic [1:0]  wr_valid;
    logic [11:0] wr_id;
    logic [63:0] wr_data;
    logic        ex_valid;
    logic [31:0] ex_op1, ex_op2;
    logic [5:0]  ex_rd;
    logic        load_hazard_o;
    logic [31:0] refetch_pc_o;

    typedef struct {
        logic        v;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [5:0]  rd;
        logic        haz;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    regfile_bypass_stage dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs2(id_use_rs2), .id_is_load(id_is_load),
        .id_op1_mode(id_op1_mode), .id_op2_mode(id_op2_mode),
        .id_imm(id_imm), .id_pc(id_pc), .flush(flush),
        .wr_valid(wr_valid), .wr_id(wr_id), .wr_data(wr_data),
        .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd),
        .load_hazard_o(load_hazard_o), .refetch_pc_o(refetch_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one expected response per issued cycle.
    always @(negedge clk) begin
        if (resetn === 1'b1 && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
            chk("load_hazard", {31'd0, load_hazard_o}, {31'd0, e.haz});
            chk("refetch_pc", refetch_pc_o, e.rpc);
            if (e.v) begin
                chk("ex_op1", ex_op1, e.op1);
                chk("ex_op2", ex_op2, e.op2);
                chk("ex_rd", {26'd0, ex_rd}, {26'd0, e.rd});
            end
        end
    end

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1 = 6'd0; id_rs2 = 6'd0; id_rd = 6'd0;
        id_use_rs2 = 1'b0; id_is_load = 1'b0; id_op1_mode = 2'd0; id_op2_mode = 2'd0;
        id_imm = 32'd0; id_pc = 32'd0; flush = 1'b0;
        wr_valid = 2'b00; wr_id = 12'd0; wr_data = 64'd0;
    endtask

    task automatic ins(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                       input logic use2, input logic ld, input logic [1:0] m1,
                       input logic [1:0] m2, input logic [31:0] imm, input logic [31:0] pc);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs2 = use2; id_is_load = ld; id_op1_mode = m1; id_op2_mode = m2;
        id_imm = imm; id_pc = pc;
    endtask

    task automatic wr(input int p, input logic [5:0] id, input logic [31:0] d);
        wr_valid[p] = 1'b1;
        wr_id[p*6 +: 6] = id;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic tick(input logic v, input logic [31:0] o1, input logic [31:0] o2,
                        input logic [5:0] rd, input logic hz, input logic [31:0] rpc);
        exp_t e;
        e.v = v; e.op1 = o1; e.op2 = o2; e.rd = rd; e.haz = hz; e.rpc = rpc;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle_inputs();
        #3;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_hazard", {31'd0, load_hazard_o}, 32'd0);
        chk("rst_op1", ex_op1, 32'd0);
        chk("rst_refetch", refetch_pc_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;

        // Writes, bypass, port priority, register 0, out-of-range id
        wr(0, 6'd5, 32'h11);                        tick(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 32'd0);
        ins(6'd5, 6'd0, 6'd9, 1'b0, 1'b0, 2'd0, 2'd1, 32'h22, 32'h10);
                                                    tick(1'b1, 32'h11, 32'h22, 6'd9, 1'b0, 32'd0);
        wr(0, 6'd7, 32'hA); wr(1, 6'd7, 32'hB);
        ins(6'd7, 6'd5, 6'd1, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'h14);
                                                    tick(1'b1, 32'hA, 32'h11, 6'd1, 1'b0, 32'd0);
        ins(6'd7, 6'd7, 6'd2, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'h18);
                                                    tick(1'b1, 32'hA, 32'hA, 6'd2, 1'b0, 32'd0);
        wr(1, 6'd8, 32'h55);
        ins(6'd8, 6'd0, 6'd10, 1'b0, 1'b0, 2'd0, 2'd2, 32'd0, 32'h1C);
                                                    tick(1'b1, 32'h55, 32'd4, 6'd10, 1'b0, 32'd0);
        wr(0, 6'd0, 32'hFF);
        ins(6'd0, 6'd0, 6'd11, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'h20);
                                                    tick(1'b1, 32'd0, 32'd0, 6'd11, 1'b0, 32'd0);
        wr(0, 6'd33, 32'h99);
        ins(6'd1, 6'd0, 6'd12, 1'b0, 1'b0, 2'd1, 2'd2, 32'd0, 32'h100);
                                                    tick(1'b1, 32'h100, 32'd4, 6'd12, 1'b0, 32'd0);
        ins(6'd1, 6'h1F, 6'd13, 1'b0, 1'b0, 2'd0, 2'd3, 32'd0, 32'h104);
                                                    tick(1'b1, 32'd0, 32'h1F, 6'd13, 1'b0, 32'd0);
        ins(6'd5, 6'h21, 6'd14, 1'b0, 1'b0, 2'd2, 2'd3, 32'd0, 32'h108);
                                                    tick(1'b1, 32'd0, 32'd1, 6'd14, 1'b0, 32'd0);
        ins(6'd5, 6'd0, 6'd15, 1'b0, 1'b0, 2'd3, 2'd1, 32'd7, 32'h10C);
                                                    tick(1'b1, 32'h11, 32'd7, 6'd15, 1'b0, 32'd0);

        // Load-use window: blocked at +1 and +4, clear at +5
        ins(6'd5, 6'd0, 6'd3, 1'b0, 1'b1, 2'd0, 2'd1, 32'd4, 32'h200);
                                                    tick(1'b1, 32'h11, 32'd4, 6'd3, 1'b0, 32'd0);
        ins(6'd3, 6'd0, 6'd4, 1'b0, 1'b0, 2'd0, 2'd1, 32'd1, 32'h204);
                                                    tick(1'b0, 32'd0, 32'd0, 6'd0, 1'b1, 32'h204);
                                                    tick(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 32'h204);
                                                    tick(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 32'h204);
        ins(6'd3, 6'd0, 6'd4, 1'b0, 1'b0, 2'd0, 2'd1, 32'd1, 32'h30C);
                                                    tick(1'b0, 32'd0, 32'd0, 6'd0, 1'b1, 32'h30C);
        ins(6'd3, 6'd0, 6'd4, 1'b0, 1'b0, 2'd0, 2'd1, 32'd1, 32'h310);
                                                    tick(1'b1, 32'd0, 32'd1, 6'd4, 1'b0, 32'h30C);

        // Store data dependency, then rs2/rs1 not consumed as registers
        ins(6'd5, 6'd0, 6'd3, 1'b0, 1'b1, 2'd0, 2'd1, 32'd0, 32'h300);
                                                    tick(1'b1, 32'h11, 32'd0, 6'd3, 1'b0, 32'h30C);
        ins(6'd5, 6'd3, 6'd0, 1'b1, 1'b0, 2'd0, 2'd0, 32'd8, 32'h304);
                                                    tick(1'b0, 32'd0, 32'd0, 6'd0, 1'b1, 32'h304);
        ins(6'd3, 6'd3, 6'd0, 1'b0, 1'b0, 2'd1, 2'd1, 32'd8, 32'h308);
                                                    tick(1'b1, 32'h308, 32'd8, 6'd0, 1'b0, 32'h304);

        // Load to x0 never blocks
        ins(6'd5, 6'd0, 6'd0, 1'b0, 1'b1, 2'd0, 2'd1, 32'd0, 32'h310);
                                                    tick(1'b1, 32'h11, 32'd0, 6'd0, 1'b0, 32'h304);
        ins(6'd0, 6'd0, 6'd16, 1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'h314);
                                                    tick(1'b1, 32'd0, 32'd0, 6'd16, 1'b0, 32'h304);

        // Flush beats hazard and clears the window
        ins(6'd5, 6'd0, 6'd5, 1'b0, 1'b1, 2'd0, 2'd1, 32'd0, 32'h400);
                                                    tick(1'b1, 32'h11, 32'd0, 6'd5, 1'b0, 32'h304);
        ins(6'd5, 6'd0, 6'd17, 1'b0, 1'b0, 2'd0, 2'd1, 32'd0, 32'h404); flush = 1'b1;
                                                    tick(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 32'h304);
        ins(6'd5, 6'd0, 6'd17, 1'b0, 1'b0, 2'd0, 2'd1, 32'd0, 32'h404);
                                                    tick(1'b1, 32'h11, 32'd0, 6'd17, 1'b0, 32'h304);
        ins(6'd5, 6'd0, 6'd6, 1'b0, 1'b1, 2'd0, 2'd1, 32'd0, 32'h500); flush = 1'b1;
                                                    tick(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 32'h304);
        ins(6'd6, 6'd0, 6'd18, 1'b0, 1'b0, 2'd0, 2'd1, 32'd0, 32'h504);
                                                    tick(1'b1, 32'd0, 32'd0, 6'd18, 1'b0, 32'h304);

        // Asynchronous reset mid-stream
        ins(6'd5, 6'd0, 6'd5, 1'b0, 1'b1, 2'd0, 2'd1, 32'd0, 32'h600);
                                                    tick(1'b1, 32'h11, 32'd0, 6'd5, 1'b0, 32'h304);
        ins(6'd5, 6'd0, 6'd19, 1'b0, 1'b0, 2'd0, 2'd1, 32'd0, 32'h604);
        @(posedge clk);
        #2;
        chk("pre_rst_hazard", {31'd0, load_hazard_o}, 32'd1);
        chk("pre_rst_refetch", refetch_pc_o, 32'h604);
        resetn = 1'b0;
        #1;
        chk("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("mid_rst_hazard", {31'd0, load_hazard_o}, 32'd0);
        chk("mid_rst_refetch", refetch_pc_o, 32'd0);
        chk("mid_rst_op1", ex_op1, 32'd0);
        chk("mid_rst_op2", ex_op2, 32'd0);
        chk("mid_rst_rd", {26'd0, ex_rd}, 32'd0);
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        ins(6'd5, 6'd0, 6'd19, 1'b0, 1'b0, 2'd0, 2'd1, 32'd0, 32'h604);
                                                    tick(1'b1, 32'd0, 32'd0, 6'd19, 1'b0, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
